cool_heat_sequencer: RTL and testbench
======================================

COOL_HEAT_SEQUENCER -- requirements
Module: cool_heat_sequencer

Interface
REQ-001 Parameter RAMP_DIV, default 16, meaning clock cycles per ramp tick (>=2).
REQ-002 Parameter STEP, default 8, meaning maximum speed change per ramp tick (1..256).
REQ-003 Parameter MIN_DWELL, default 64, meaning minimum cycles spent in HEAT or COOL before a temperature-driven exit.
REQ-004 Parameter HYST, default 2, meaning hysteresis in temperature units applied on exit.
REQ-005 Port clk  input  1  clock; all state updates on its rising edge.
REQ-006 Port arst  input  1  asynchronous, active-low reset.
REQ-007 Port en  input  1  system enable; low forces shutdown sequence.
REQ-008 Port temp  input  8  measured temperature, unsigned.
REQ-009 Port t_low  input  8  heat threshold, unsigned.
REQ-010 Port t_high  input  8  cool threshold, unsigned.
REQ-011 Port heater_on  output  1  heater relay enable.
REQ-012 Port cooler_on  output  1  cooler relay enable.
REQ-013 Port speed  output  9  fan PWM duty command, 0..256 (256 = 100 %), fed to the PWM generator.
REQ-014 Port state  output  2  current state: IDLE=00, HEAT=01, COOL=10, DRAIN=11.

Function
REQ-015 All outputs SHALL be registered; every decision uses inputs sampled on the same rising edge.
REQ-016 IDLE: heater_on=0, cooler_on=0, speed=0; ramp-tick and dwell counters held at 0.
REQ-017 IDLE->HEAT when en=1, t_low<=t_high and temp<t_low; IDLE->COOL when en=1, t_low<=t_high and temp>t_high; t_low>t_high (misconfig) SHALL hold IDLE.
REQ-018 HEAT SHALL drive heater_on=1, cooler_on=0; COOL SHALL drive cooler_on=1, heater_on=0; relay outputs assert on the first cycle state shows HEAT/COOL.
REQ-019 Error: HEAT err=t_low-temp, COOL err=temp-t_high, clamped to 0 when negative; computed at 9+ bits, no wrap.
REQ-020 Target speed = min(256, 64 + 16*err) in HEAT/COOL; target = 0 in DRAIN and IDLE.
REQ-021 Ramp tick: modulo-RAMP_DIV counter, free-running outside IDLE; tick asserted on the cycle count==RAMP_DIV-1, first tick RAMP_DIV cycles after leaving IDLE.
REQ-022 On each tick speed SHALL move toward target by min(STEP, |target-speed|); never overshoot; speed unchanged between ticks; speed never exceeds 256.
REQ-023 Dwell counter counts cycles in HEAT/COOL, saturating at MIN_DWELL; cleared on entry to HEAT/COOL.
REQ-024 HEAT->DRAIN when dwell==MIN_DWELL and temp>=t_low+HYST (sum computed at 9 bits, so t_low+HYST>255 is never met by temp); COOL->DRAIN when dwell==MIN_DWELL and temp+HYST<=t_high.
REQ-025 en=0 in HEAT or COOL SHALL force DRAIN on the next edge regardless of dwell.
REQ-026 DRAIN: heater_on=0, cooler_on=0 immediately; speed ramps to 0 per REQ-022; DRAIN->IDLE on the edge after speed reaches 0; speed==0 on DRAIN entry -> IDLE next edge.
REQ-027 Direct HEAT<->COOL transitions SHALL never occur; heater_on and cooler_on SHALL never both be 1.
REQ-028 Threshold or temp changes mid-HEAT/COOL SHALL only alter target; state changes follow REQ-024/025 only.

Reset
REQ-029 arst low SHALL asynchronously force state=IDLE, speed=0, heater_on=0, cooler_on=0, all counters 0, including mid-ramp or mid-DRAIN.
REQ-030 After arst deasserts, first transition evaluated on the next rising edge; no state retained.

Verification
REQ-031 Reset, en=1, t_low=20, t_high=30, temp=25 for 500 cycles -> state=IDLE, speed=0, both relays 0.
REQ-032 temp=10 (err=10, target=224), defaults -> HEAT, heater_on=1, speed 8,16,... every 16 cycles, reaches 224 after 28 ticks and holds.
REQ-033 In HEAT with speed=224, temp->22 at dwell<64 -> stays HEAT until dwell=64, then DRAIN, heater_on=0, speed falls 8 per 16 cycles, IDLE 1 cycle after speed=0.
REQ-034 temp=40, COOL at speed=96, en->0 -> DRAIN next edge, cooler_on=0, ramp down to 0, IDLE; no HEAT entry even if temp then <t_low until IDLE.
REQ-035 t_low=50, t_high=40, temp=0 -> remains IDLE; arst pulsed mid-DRAIN with speed=120 -> speed=0, state=IDLE immediately, before next clk edge.

Source files
------------

// File: rtl/cool_heat_sequencer.sv
// cool_heat_sequencer: heat/cool relay sequencer with a ramped fan-speed command.
//   IDLE waits for temp to leave the [t_low, t_high] band. HEAT or COOL then drives
//   its relay while the fan speed ramps toward an error-proportional target. An exit
//   requires a minimum dwell plus hysteresis; dropping en forces an exit at once.
//   DRAIN switches both relays off, ramps the fan to 0 and then returns to IDLE.
// Ports:
//   clk             rising-edge clock
//   arst            asynchronous active-low reset
//   en              system enable; low forces the shutdown sequence
//   temp            measured temperature (unsigned 8-bit)
//   t_low, t_high   heat and cool thresholds (unsigned 8-bit)
//   heater_on       registered heater relay enable
//   cooler_on       registered cooler relay enable
//   speed           registered fan duty, 0..256
//   state           current state: IDLE=00, HEAT=01, COOL=10, DRAIN=11
module cool_heat_sequencer #(
  parameter int RAMP_DIV  = 16,
  parameter int STEP      = 8,
  parameter int MIN_DWELL = 64,
  parameter int HYST      = 2
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       en,
  input  logic [7:0] temp,
  input  logic [7:0] t_low,
  input  logic [7:0] t_high,
  output logic       heater_on,
  output logic       cooler_on,
  output logic [8:0] speed,
  output logic [1:0] state
);

  localparam int CW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [8:0]    STEP_V    = 9'(STEP);
  localparam logic [8:0]    HYST_V    = 9'(HYST);

  typedef enum logic [1:0] {IDLE = 2'b00, HEAT = 2'b01, COOL = 2'b10, DRAIN = 2'b11} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [8:0]    speed_q, speed_d;
  logic          heater_q, heater_d, cooler_q, cooler_d;

  logic          tick;
  logic [7:0]    err;
  logic [12:0]   target_raw;
  logic [8:0]    target, diff, delta;
  logic [8:0]    heat_exit_thr, cool_exit_sum;

  assign tick = (state_q != IDLE) && (tick_cnt_q == TICK_LAST);

  // Exit thresholds are formed at 9 bits so t_low+HYST cannot wrap into reach.
  assign heat_exit_thr = {1'b0, t_low} + HYST_V;
  assign cool_exit_sum = {1'b0, temp} + HYST_V;

  always_comb begin
    err = '0;
    if (state_q == HEAT && t_low > temp) err = t_low - temp;
    if (state_q == COOL && temp > t_high) err = temp - t_high;
  end

  // 64 + 16*err needs 13 bits before the clamp at full duty.
  assign target_raw = 13'd64 + {1'b0, err, 4'b0000};
  always_comb begin
    target = '0;
    if (state_q == HEAT || state_q == COOL)
      target = (target_raw > 13'd256) ? 9'd256 : target_raw[8:0];
  end

  always_comb begin
    diff  = (target > speed_q) ? (target - speed_q) : (speed_q - target);
    delta = (diff < STEP_V) ? diff : STEP_V;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en && t_low <= t_high) begin
          if (temp < t_low)       state_d = HEAT;
          else if (temp > t_high) state_d = COOL;
        end
      end
      HEAT: begin
        if (!en) state_d = DRAIN;
        else if (dwell_q == DWELL_MAX && {1'b0, temp} >= heat_exit_thr) state_d = DRAIN;
      end
      COOL: begin
        if (!en) state_d = DRAIN;
        else if (dwell_q == DWELL_MAX && cool_exit_sum <= {1'b0, t_high}) state_d = DRAIN;
      end
      DRAIN: begin
        if (speed_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    // Counter parks at 0 in IDLE and restarts from 0 when IDLE is left, so the
    // first tick lands RAMP_DIV cycles after the exit.
    tick_cnt_d = '0;
    if (state_q != IDLE && state_d != IDLE && !tick) tick_cnt_d = tick_cnt_q + 1'b1;

    // Dwell only runs while staying in HEAT/COOL; entry and exit both clear it.
    dwell_d = '0;
    if ((state_q == HEAT || state_q == COOL) && state_d == state_q)
      dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;

    speed_d = speed_q;
    if (tick) speed_d = (target > speed_q) ? (speed_q + delta) : (speed_q - delta);
    if (state_d == IDLE) speed_d = '0;

    // Relays follow the next state so they assert together with the state change.
    heater_d = (state_d == HEAT);
    cooler_d = (state_d == COOL);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      dwell_q    <= '0;
      speed_q    <= '0;
      heater_q   <= 1'b0;
      cooler_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      dwell_q    <= dwell_d;
      speed_q    <= speed_d;
      heater_q   <= heater_d;
      cooler_q   <= cooler_d;
    end
  end

  assign heater_on = heater_q;
  assign cooler_on = cooler_q;
  assign speed     = speed_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cool_heat_sequencer.sv
// Directed bench for cool_heat_sequencer with default parameters. Expected
// snapshots are queued as stimulus is applied and compared after the DUT reacts.
module tb_cool_heat_sequencer;

  localparam int S_IDLE = 0, S_HEAT = 1, S_COOL = 2, S_DRAIN = 3;

  logic       clk = 1'b0;
  logic       arst;
  logic       en;
  logic [7:0] temp, t_low, t_high;
  logic       heater_on, cooler_on;
  logic [8:0] speed;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    int    st;
    int    spd;
    int    h;
    int    c;
  } exp_t;
  exp_t sb[$];

  cool_heat_sequencer dut (
    .clk      (clk),
    .arst     (arst),
    .en       (en),
    .temp     (temp),
    .t_low    (t_low),
    .t_high   (t_high),
    .heater_on(heater_on),
    .cooler_on(cooler_on),
    .speed    (speed),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, sample 1 time unit later, and check relay exclusivity
  // and the duty ceiling on every cycle.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cmp("relay_excl", int'(heater_on & cooler_on), 0);
      cmp("speed_cap", int'(speed > 9'd256), 0);
    end
  endtask

  task automatic push(input string tag, input int st, input int spd, input int h, input int c);
    exp_t e;
    e.tag = tag; e.st = st; e.spd = spd; e.h = h; e.c = c;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.tag, ".state"},  int'(state),     e.st);
      cmp({e.tag, ".speed"},  int'(speed),     e.spd);
      cmp({e.tag, ".heater"}, int'(heater_on), e.h);
      cmp({e.tag, ".cooler"}, int'(cooler_on), e.c);
    end
  endtask

  // Follow DRAIN down to 0: each move is -8, moves are 16 cycles apart, then
  // IDLE follows one edge after speed reaches 0.
  task automatic ramp_down(input string tag);
    int old, n;
    bit first;
    first = 1'b1;
    old = int'(speed);
    while (old > 0) begin
      n = 0;
      while (int'(speed) == old && n < 20) begin
        step(1);
        n++;
      end
      push(tag, S_DRAIN, (old > 8) ? old - 8 : 0, 0, 0);
      check_sb();
      if (!first) cmp({tag, ".gap"}, n, 16);
      first = 1'b0;
      if (int'(speed) == old) break;
      old = int'(speed);
    end
    step(1);
    push({tag, ".idle"}, S_IDLE, 0, 0, 0);
    check_sb();
  endtask

  initial begin
    arst = 1'b0; en = 1'b1; t_low = 8'd20; t_high = 8'd30; temp = 8'd25;
    #12;
    push("reset", S_IDLE, 0, 0, 0);
    check_sb();
    arst = 1'b1;

    // In-band temperature: stays idle.
    step(500);
    push("inband", S_IDLE, 0, 0, 0);
    check_sb();

    // Heat, err=10 -> target 224, +8 every 16 cycles.
    temp = 8'd10;
    step(1);
    push("heat_entry", S_HEAT, 0, 1, 0);
    check_sb();
    for (int k = 1; k <= 28; k++) begin
      step(16);
      push("heat_ramp", S_HEAT, 8 * k, 1, 0);
      check_sb();
    end
    step(32);
    push("heat_hold", S_HEAT, 224, 1, 0);
    check_sb();

    // Dwell already satisfied: temp reaching t_low+HYST exits at once.
    temp = 8'd22;
    step(1);
    push("heat_exit", S_DRAIN, 224, 0, 0);
    check_sb();
    ramp_down("drain224");

    // Exit condition met while dwell < 64: held until dwell saturates; 21 is
    // one below the hysteresis boundary and must not exit.
    temp = 8'd10;
    step(1);
    push("heat2_entry", S_HEAT, 0, 1, 0);
    check_sb();
    step(10);
    temp = 8'd21;
    step(54);
    push("dwell_hold", S_HEAT, 32, 1, 0);
    check_sb();
    step(5);
    push("hyst_hold", S_HEAT, 32, 1, 0);
    check_sb();
    temp = 8'd22;
    step(1);
    push("hyst_exit", S_DRAIN, 32, 0, 0);
    check_sb();
    ramp_down("drain32");

    // Cool to speed 96, then en drop forces DRAIN; a cold temp must not
    // start HEAT until DRAIN has finished.
    temp = 8'd40;
    step(1);
    push("cool_entry", S_COOL, 0, 0, 1);
    check_sb();
    step(192);
    push("cool_96", S_COOL, 96, 0, 1);
    check_sb();
    en = 1'b0;
    step(1);
    push("cool_en_off", S_DRAIN, 96, 0, 0);
    check_sb();
    en = 1'b1;
    temp = 8'd10;
    ramp_down("drain96");
    step(1);
    push("heat_after_idle", S_HEAT, 0, 1, 0);
    check_sb();

    // Misconfigured thresholds hold IDLE.
    arst = 1'b0;
    step(2);
    arst = 1'b1;
    t_low = 8'd50; t_high = 8'd40; temp = 8'd0;
    step(100);
    push("misconfig", S_IDLE, 0, 0, 0);
    check_sb();

    // Asynchronous reset mid-DRAIN at speed 120.
    t_low = 8'd20; t_high = 8'd30;
    step(1);
    push("heat3_entry", S_HEAT, 0, 1, 0);
    check_sb();
    step(240);
    push("heat3_120", S_HEAT, 120, 1, 0);
    check_sb();
    en = 1'b0;
    step(1);
    push("drain120", S_DRAIN, 120, 0, 0);
    check_sb();
    step(5);
    push("drain120_hold", S_DRAIN, 120, 0, 0);
    check_sb();
    #2;
    arst = 1'b0;
    #1;
    push("async_reset", S_IDLE, 0, 0, 0);
    check_sb();
    arst = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
